conv_column_feeder: RTL and testbench
=====================================

CONV_COLUMN_FEEDER -- requirements
Module: conv_column_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 224: pixels per image row.
REQ-003 Parameter IMG_HEIGHT, default 224: rows per frame.
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port pixel_in, input, DATA_WIDTH: raster-order pixel data.
REQ-007 Port pixel_valid, input, 1: pixel_in is valid this cycle.
REQ-008 Port pixel_sof, input, 1: qualified by pixel_valid; marks the pixel as row 0, column 0.
REQ-009 Port pixel_ready, output, 1: the block accepts a pixel this cycle (accept = pixel_valid & pixel_ready).
REQ-010 Port input_col, output, 3*DATA_WIDTH: column {top, mid, bottom}, with top in the MSBs.
REQ-011 Port col, output, 1: input_col is valid this cycle. It drives the col input of the downstream 3x3 array.
REQ-012 Port frame_done, output, 1: one-cycle pulse after the last column of a frame.
REQ-013 Port sof_err, output, 1: one-cycle pulse when a frame is aborted by an early SOF.

Function
REQ-014 States SHALL be IDLE, FILL, STREAM and DONE.
REQ-015 The block SHALL hold a column counter (0..IMG_WIDTH-1) and a row counter (0..IMG_HEIGHT-1).
REQ-016 On each accept, the column counter SHALL increment. It wraps to 0 after IMG_WIDTH-1, and the row counter increments on that wrap.
REQ-017 The block SHALL keep two line buffers of IMG_WIDTH entries: LB_A holds row r-2 and LB_B holds row r-1.
- On each accept at column c, LB_A[c] takes LB_B[c], and LB_B[c] takes pixel_in.
REQ-018 IDLE behaviour:
- pixel_ready = 1.
- Accepts with sof = 0 SHALL be discarded with no state change.
- An accept with sof = 1 stores pixel (0,0) and moves to FILL.
REQ-019 FILL covers rows 0 and 1. Pixels are written to the line buffers and col stays 0. The accept of pixel (1, IMG_WIDTH-1) moves to STREAM.
REQ-020 STREAM covers rows 2..IMG_HEIGHT-1. The cycle after each accept at (r,c), the block SHALL drive:
- col = 1
- input_col = {LB_A[c], LB_B[c], pixel_in}, all values read before the update.
REQ-021 Column latency SHALL be exactly 1 cycle from accept to col.
REQ-022 Throughput SHALL be one column per cycle under continuous pixel_valid.
REQ-023 Columns per frame SHALL be (IMG_HEIGHT-2)*IMG_WIDTH, delivered in raster order with no gaps other than gaps in pixel_valid.
REQ-024 The accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL move to DONE.
- In DONE, pixel_ready = 0 and frame_done = 1 for exactly one cycle, coincident with the last col pulse.
- The next state is IDLE.
REQ-025 In FILL or STREAM, an accept with sof = 1 SHALL:
- pulse sof_err for 1 cycle;
- suppress col for that pixel;
- treat that pixel as (0,0) of a new frame and enter FILL.
REQ-026 Between accepts, col SHALL be 0 and input_col SHALL hold its last value.
REQ-027 pixel_ready SHALL be a registered function of state only, with no combinational path from pixel_valid.
REQ-028 The block SHALL NOT apply backpressure downstream; the consumer must accept every col pulse.
REQ-029 Pixel values SHALL pass through unmodified; no arithmetic is performed on data.

Reset
REQ-030 While rst = 1, the outputs SHALL be:
- state = IDLE
- both counters = 0
- col = 0, frame_done = 0, sof_err = 0
- input_col = 0
- pixel_ready = 0
REQ-031 On the first cycle after rst deasserts, pixel_ready SHALL be 1.
REQ-032 Line buffer contents SHALL NOT be reset. Their reset values SHALL be unobservable because FILL rewrites both rows before any col.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately. No col or frame_done SHALL follow until a new SOF and two full rows.

Verification (IMG_WIDTH = 4, IMG_HEIGHT = 4, pixel value = 16*row + col)
REQ-034 Continuous stream of one frame:
- No col during the first 8 accepts.
- Then exactly 8 col pulses.
- First input_col = 0x001020; the fifth = 0x102030.
- frame_done coincides with the 8th col, whose input_col = 0x132333.
REQ-035 Send pixel_valid with sof = 0 in IDLE for 5 cycles, then a valid frame: the 5 pixels are dropped and the output matches REQ-034 exactly.
REQ-036 Insert random pixel_valid gaps:
- The col sequence and values are identical to REQ-034.
- Each col appears exactly 1 cycle after its accept.
REQ-037 Send sof at pixel (2,1):
- sof_err pulses once and no col is emitted for that pixel.
- The new frame then yields 8 columns as in REQ-034.
REQ-038 Assert rst during pixel (3,0):
- All outputs go to 0 asynchronously.
- Post-reset, a full frame reproduces REQ-034.
REQ-039 Two back-to-back frames: pixel_ready = 0 for exactly one cycle (DONE) between frames, and the second frame matches REQ-034.

Source files
------------

// File: rtl/conv_column_feeder.sv
// conv_column_feeder: turns a raster pixel stream into 3-pixel
// vertical columns {row r-2, row r-1, row r} for a 3x3 array.
module conv_column_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 224,
    parameter int IMG_HEIGHT = 224
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic                    pixel_valid,
    input  logic                    pixel_sof,
    output logic                    pixel_ready,
    output logic [3*DATA_WIDTH-1:0] input_col,
    output logic                    col,
    output logic                    frame_done,
    output logic                    sof_err
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_col_cnt;
    logic [RW-1:0]           r_row_cnt;
    logic                    r_ready;
    logic                    r_col;
    logic                    r_frame_done;
    logic                    r_sof_err;
    logic [3*DATA_WIDTH-1:0] r_input_col;

    logic [DATA_WIDTH-1:0]   r_lb_a [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   r_lb_b [IMG_WIDTH];

    logic                    w_accept;
    logic                    w_data;
    logic                    w_emit;
    logic                    w_restart;
    logic [CW-1:0]           w_pos_col;
    logic [RW-1:0]           w_pos_row;
    logic                    w_pos_last_col;
    logic                    w_pos_last_row;

    // An SOF pixel is always position (0,0), whatever the counters say.
    assign w_accept       = pixel_valid & r_ready;
    assign w_pos_col      = pixel_sof ? '0 : r_col_cnt;
    assign w_pos_row      = pixel_sof ? '0 : r_row_cnt;
    assign w_pos_last_col = (w_pos_col == CW'(IMG_WIDTH - 1));
    assign w_pos_last_row = (w_pos_row == RW'(IMG_HEIGHT - 1));

    assign w_data    = w_accept & (pixel_sof | (r_state != S_IDLE));
    assign w_emit    = w_accept & ~pixel_sof & (r_state == S_STREAM);
    assign w_restart = w_accept & pixel_sof &
                       ((r_state == S_FILL) | (r_state == S_STREAM));

    // Next-state decode from the current state and the accepted pixel.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && pixel_sof)
                    w_next = S_FILL;
            end
            S_FILL: begin
                if (w_accept && !pixel_sof && w_pos_last_col &&
                    (w_pos_row == RW'(1)))
                    w_next = S_STREAM;
            end
            S_STREAM: begin
                if (w_accept && pixel_sof)
                    w_next = S_FILL;
                else if (w_accept && w_pos_last_col && w_pos_last_row)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; ready is registered from the next state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != S_DONE);
        end
    end

    // Raster position of the next expected pixel; wraps at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_data) begin
            if (w_pos_last_col) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_pos_last_row ? '0 : w_pos_row + 1'b1;
            end else begin
                r_col_cnt <= w_pos_col + 1'b1;
                r_row_cnt <= w_pos_row;
            end
        end
    end

    // Line buffers shift one row down at the written column.
    always_ff @(posedge clk) begin
        if (w_data) begin
            r_lb_a[w_pos_col] <= r_lb_b[w_pos_col];
            r_lb_b[w_pos_col] <= pixel_in;
        end
    end

    // Column output, frame-end and abort pulses, one cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
            r_input_col  <= '0;
        end else begin
            r_col        <= w_emit;
            r_frame_done <= w_emit & w_pos_last_col & w_pos_last_row;
            r_sof_err    <= w_restart;
            if (w_emit)
                r_input_col <= {r_lb_a[w_pos_col],
                                r_lb_b[w_pos_col],
                                pixel_in};
        end
    end

    assign pixel_ready = r_ready;
    assign input_col   = r_input_col;
    assign col         = r_col;
    assign frame_done  = r_frame_done;
    assign sof_err     = r_sof_err;

endmodule

// File: tb/tb_conv_column_feeder.sv
// Bench for conv_column_feeder on a 4x4 image, pixel = 16*row + col.
// Expected columns are queued on accept and popped when col fires.
module tb_conv_column_feeder;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef struct {
        logic [3*DW-1:0] val;
        bit              done;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   pixel_in = '0;
    logic            pixel_valid = 1'b0;
    logic            pixel_sof = 1'b0;
    logic            pixel_ready;
    logic [3*DW-1:0] input_col;
    logic            col;
    logic            frame_done;
    logic            sof_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   col_cnt = 0;
    int   sof_cnt = 0;
    exp_t q[$];

    conv_column_feeder #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_sof  (pixel_sof),
        .pixel_ready(pixel_ready),
        .input_col  (input_col),
        .col        (col),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every col pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (col) begin
                checks++;
                col_cnt++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_col: got col=%h at cyc %0d, required none",
                             input_col, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (input_col !== e.val || frame_done !== e.done ||
                        cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL column: got %h done=%b cyc=%0d, required %h done=%b cyc=%0d",
                                 input_col, frame_done, cyc, e.val, e.done, e.cyc);
                    end
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL stray_frame_done: got 1 without col, required 0");
            end
            if (sof_err) sof_cnt++;
        end
    end

    // Present one pixel until accepted; queue its expected column.
    task automatic send_px(input logic [DW-1:0] d, input logic sof,
                           input bit ec, input logic [3*DW-1:0] ev,
                           input bit ed);
        int guard;
        guard = 0;
        pixel_valid = 1'b1;
        pixel_in    = d;
        pixel_sof   = sof;
        while (!pixel_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!pixel_ready) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: got pixel_ready=0 for 20 cycles, required 1");
        end else if (ec) begin
            exp_t e;
            e.val  = ev;
            e.done = ed;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Send raster indices first..last of a frame, optional valid gaps.
    task automatic send_frame(input bit gaps, input int first,
                              input int last);
        for (int i = first; i <= last; i++) begin
            int r, c;
            logic [3*DW-1:0] ev;
            r = i / W;
            c = i % W;
            ev = {8'(16*(r-2)+c), 8'(16*(r-1)+c), 8'(16*r+c)};
            send_px(8'(16*r+c), (i == 0), (r >= 2), ev,
                    (r == H-1) && (c == W-1));
            if (gaps) begin
                pixel_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (pixel_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 0", pixel_ready);
        end
        if (col !== 1'b0) begin
            errors++;
            $display("FAIL reset_col: got %b, required 0", col);
        end
        if (input_col !== '0) begin
            errors++;
            $display("FAIL reset_input_col: got %h, required 0", input_col);
        end
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done: got %b, required 0", frame_done);
        end
        if (sof_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_sof_err: got %b, required 0", sof_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pixel_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b, required 1", pixel_ready);
        end
    endtask

    task automatic test_frame(input bit gaps, input string nm);
        int c0, s0;
        c0 = col_cnt;
        s0 = sof_cnt;
        send_frame(gaps, 0, W*H-1);
        repeat (3) @(negedge clk);
        checks += 3;
        if (col_cnt - c0 !== 8) begin
            errors++;
            $display("FAIL %s_count: got %0d cols, required 8", nm, col_cnt - c0);
        end
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d missing cols, required 0", nm, q.size());
        end
        if (sof_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL %s_sof_err: got %0d pulses, required 0", nm, sof_cnt - s0);
        end
    endtask

    task automatic test_idle_drop();
        int c0;
        c0 = col_cnt;
        for (int i = 0; i < 5; i++)
            send_px(8'($urandom_range(0, 255)), 1'b0, 1'b0, '0, 1'b0);
        pixel_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (col_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL idle_drop_cols: got %0d, required 0", col_cnt - c0);
        end
        test_frame(1'b0, "idle_drop");
    endtask

    task automatic test_sof_abort();
        int c0, s0;
        c0 = col_cnt;
        s0 = sof_cnt;
        send_frame(1'b0, 0, 2*W);
        send_frame(1'b0, 0, W*H-1);
        repeat (3) @(negedge clk);
        checks += 3;
        if (sof_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL sof_abort_pulses: got %0d, required 1", sof_cnt - s0);
        end
        if (col_cnt - c0 !== 9) begin
            errors++;
            $display("FAIL sof_abort_count: got %0d cols, required 9", col_cnt - c0);
        end
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL sof_abort_pending: got %0d, required 0", q.size());
        end
    endtask

    task automatic test_mid_reset();
        send_frame(1'b0, 0, 3*W-1);
        pixel_valid = 1'b1;
        pixel_in    = 8'h30;
        pixel_sof   = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if ({col, frame_done, sof_err, pixel_ready} !== 4'b0 ||
            input_col !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got col=%b done=%b err=%b rdy=%b ic=%h, required all 0",
                     col, frame_done, sof_err, pixel_ready, input_col);
        end
        pixel_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL mid_reset_pending: got %0d, required 0", q.size());
        end
        rst = 1'b0;
        @(negedge clk);
        test_frame(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = col_cnt;
        send_frame(1'b0, 0, W*H-1);
        checks += 2;
        if (pixel_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ready: got %b, required 0", pixel_ready);
        end
        @(negedge clk);
        if (pixel_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ready: got %b, required 1", pixel_ready);
        end
        send_frame(1'b0, 0, W*H-1);
        repeat (3) @(negedge clk);
        checks += 2;
        if (col_cnt - c0 !== 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d cols, required 16", col_cnt - c0);
        end
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d, required 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, "continuous");
        test_idle_drop();
        test_frame(1'b1, "gaps");
        test_sof_abort();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
